// File: rtl/calc_rs.sv
// calc_rs: reservation station for integer-calculate instructions.
// Holds issued instructions until both operands are known, snoops the ALU and
// LSB common data buses, and dispatches the lowest-index ready entry each cycle.
module calc_rs #(
    parameter int unsigned RS_SIZE = 8,
    parameter int unsigned TYPE_W  = 6,
    parameter int unsigned ROB_W   = 4,
    parameter int unsigned XLEN    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              flush,
    input  logic              issue_valid,
    input  logic              issue_is_calc,
    input  logic [TYPE_W-1:0] issue_type,
    input  logic              issue_qj_busy,
    input  logic [ROB_W-1:0]  issue_qj,
    input  logic [XLEN-1:0]   issue_vj,
    input  logic              issue_qk_busy,
    input  logic [ROB_W-1:0]  issue_qk,
    input  logic [XLEN-1:0]   issue_vk,
    input  logic [XLEN-1:0]   issue_imm,
    input  logic [XLEN-1:0]   issue_pc,
    input  logic [ROB_W-1:0]  issue_dest,
    input  logic              alu_cdb_valid,
    input  logic [ROB_W-1:0]  alu_cdb_tag,
    input  logic [XLEN-1:0]   alu_cdb_value,
    input  logic              lsb_cdb_valid,
    input  logic [ROB_W-1:0]  lsb_cdb_tag,
    input  logic [XLEN-1:0]   lsb_cdb_value,
    output logic              rs_full,
    output logic              alu_valid,
    output logic [TYPE_W-1:0] alu_type,
    output logic [XLEN-1:0]   alu_a,
    output logic [XLEN-1:0]   alu_b,
    output logic [XLEN-1:0]   alu_imm,
    output logic [XLEN-1:0]   alu_pc,
    output logic [ROB_W-1:0]  alu_dest
);

    localparam int unsigned IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

    typedef struct packed {
        logic              busy;
        logic [TYPE_W-1:0] itype;
        logic              qj_busy;
        logic [ROB_W-1:0]  qj;
        logic [XLEN-1:0]   vj;
        logic              qk_busy;
        logic [ROB_W-1:0]  qk;
        logic [XLEN-1:0]   vk;
        logic [XLEN-1:0]   imm;
        logic [XLEN-1:0]   pc;
        logic [ROB_W-1:0]  dest;
    } entry_t;

    entry_t            entry_q [RS_SIZE];
    entry_t            entry_d [RS_SIZE];
    entry_t            new_entry;

    logic              alu_valid_q, alu_valid_d;
    logic [TYPE_W-1:0] alu_type_q,  alu_type_d;
    logic [XLEN-1:0]   alu_a_q,     alu_a_d;
    logic [XLEN-1:0]   alu_b_q,     alu_b_d;
    logic [XLEN-1:0]   alu_imm_q,   alu_imm_d;
    logic [XLEN-1:0]   alu_pc_q,    alu_pc_d;
    logic [ROB_W-1:0]  alu_dest_q,  alu_dest_d;

    logic              free_found;
    logic [IDX_W-1:0]  free_idx;
    logic              ready_found;
    logic [IDX_W-1:0]  ready_idx;
    logic              accept;

    // Entry selection, accept with CDB forwarding, snoop, dispatch and flush.
    always_comb begin
        entry_d     = entry_q;
        alu_valid_d = alu_valid_q;
        alu_type_d  = alu_type_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_imm_d   = alu_imm_q;
        alu_pc_d    = alu_pc_q;
        alu_dest_d  = alu_dest_q;
        free_found  = 1'b0;
        free_idx    = '0;
        ready_found = 1'b0;
        ready_idx   = '0;
        new_entry   = '0;

        for (int i = 0; i < int'(RS_SIZE); i++) begin
            if (!free_found && !entry_q[i].busy) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
            if (!ready_found && entry_q[i].busy && !entry_q[i].qj_busy && !entry_q[i].qk_busy) begin
                ready_found = 1'b1;
                ready_idx   = IDX_W'(i);
            end
        end

        rs_full = !free_found;
        accept  = rdy && !flush && issue_valid && issue_is_calc && !rs_full;

        // Incoming instruction, picking up an operand broadcast in the same cycle.
        new_entry.busy    = 1'b1;
        new_entry.itype   = issue_type;
        new_entry.qj_busy = issue_qj_busy;
        new_entry.qj      = issue_qj;
        new_entry.vj      = issue_vj;
        new_entry.qk_busy = issue_qk_busy;
        new_entry.qk      = issue_qk;
        new_entry.vk      = issue_vk;
        new_entry.imm     = issue_imm;
        new_entry.pc      = issue_pc;
        new_entry.dest    = issue_dest;
        if (issue_qj_busy) begin
            if (alu_cdb_valid && alu_cdb_tag == issue_qj) begin
                new_entry.qj_busy = 1'b0;
                new_entry.vj      = alu_cdb_value;
            end else if (lsb_cdb_valid && lsb_cdb_tag == issue_qj) begin
                new_entry.qj_busy = 1'b0;
                new_entry.vj      = lsb_cdb_value;
            end
        end
        if (issue_qk_busy) begin
            if (alu_cdb_valid && alu_cdb_tag == issue_qk) begin
                new_entry.qk_busy = 1'b0;
                new_entry.vk      = alu_cdb_value;
            end else if (lsb_cdb_valid && lsb_cdb_tag == issue_qk) begin
                new_entry.qk_busy = 1'b0;
                new_entry.vk      = lsb_cdb_value;
            end
        end

        if (rdy) begin
            if (flush) begin
                for (int i = 0; i < int'(RS_SIZE); i++) begin
                    entry_d[i].busy = 1'b0;
                end
                alu_valid_d = 1'b0;
            end else begin
                for (int i = 0; i < int'(RS_SIZE); i++) begin
                    if (entry_q[i].busy && entry_q[i].qj_busy) begin
                        if (alu_cdb_valid && alu_cdb_tag == entry_q[i].qj) begin
                            entry_d[i].qj_busy = 1'b0;
                            entry_d[i].vj      = alu_cdb_value;
                        end else if (lsb_cdb_valid && lsb_cdb_tag == entry_q[i].qj) begin
                            entry_d[i].qj_busy = 1'b0;
                            entry_d[i].vj      = lsb_cdb_value;
                        end
                    end
                    if (entry_q[i].busy && entry_q[i].qk_busy) begin
                        if (alu_cdb_valid && alu_cdb_tag == entry_q[i].qk) begin
                            entry_d[i].qk_busy = 1'b0;
                            entry_d[i].vk      = alu_cdb_value;
                        end else if (lsb_cdb_valid && lsb_cdb_tag == entry_q[i].qk) begin
                            entry_d[i].qk_busy = 1'b0;
                            entry_d[i].vk      = lsb_cdb_value;
                        end
                    end
                end

                if (ready_found) begin
                    alu_valid_d             = 1'b1;
                    alu_type_d              = entry_q[ready_idx].itype;
                    alu_a_d                 = entry_q[ready_idx].vj;
                    alu_b_d                 = entry_q[ready_idx].vk;
                    alu_imm_d               = entry_q[ready_idx].imm;
                    alu_pc_d                = entry_q[ready_idx].pc;
                    alu_dest_d              = entry_q[ready_idx].dest;
                    entry_d[ready_idx].busy = 1'b0;
                end else begin
                    alu_valid_d = 1'b0;
                end

                // Free slot is never the dispatching one, so this cannot collide.
                if (accept) begin
                    entry_d[free_idx] = new_entry;
                end
            end
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(RS_SIZE); i++) begin
                entry_q[i] <= '0;
            end
            alu_valid_q <= 1'b0;
            alu_type_q  <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_imm_q   <= '0;
            alu_pc_q    <= '0;
            alu_dest_q  <= '0;
        end else begin
            for (int i = 0; i < int'(RS_SIZE); i++) begin
                entry_q[i] <= entry_d[i];
            end
            alu_valid_q <= alu_valid_d;
            alu_type_q  <= alu_type_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_imm_q   <= alu_imm_d;
            alu_pc_q    <= alu_pc_d;
            alu_dest_q  <= alu_dest_d;
        end
    end

    assign alu_valid = alu_valid_q;
    assign alu_type  = alu_type_q;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_imm   = alu_imm_q;
    assign alu_pc    = alu_pc_q;
    assign alu_dest  = alu_dest_q;

endmodule

// File: tb/tb_calc_rs.sv
// Directed bench for calc_rs: dispatch latency, CDB capture, full/flush/reset/rdy.
module tb_calc_rs;

    localparam logic [5:0] T_ADDI = 6'd10;
    localparam logic [5:0] T_ADD  = 6'd20;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        flush;
    logic        issue_valid;
    logic        issue_is_calc;
    logic [5:0]  issue_type;
    logic        issue_qj_busy;
    logic [3:0]  issue_qj;
    logic [31:0] issue_vj;
    logic        issue_qk_busy;
    logic [3:0]  issue_qk;
    logic [31:0] issue_vk;
    logic [31:0] issue_imm;
    logic [31:0] issue_pc;
    logic [3:0]  issue_dest;
    logic        alu_cdb_valid;
    logic [3:0]  alu_cdb_tag;
    logic [31:0] alu_cdb_value;
    logic        lsb_cdb_valid;
    logic [3:0]  lsb_cdb_tag;
    logic [31:0] lsb_cdb_value;
    logic        rs_full;
    logic        alu_valid;
    logic [5:0]  alu_type;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] alu_imm;
    logic [31:0] alu_pc;
    logic [3:0]  alu_dest;

    int checks = 0;
    int errors = 0;

    calc_rs dut (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
        .issue_valid(issue_valid), .issue_is_calc(issue_is_calc), .issue_type(issue_type),
        .issue_qj_busy(issue_qj_busy), .issue_qj(issue_qj), .issue_vj(issue_vj),
        .issue_qk_busy(issue_qk_busy), .issue_qk(issue_qk), .issue_vk(issue_vk),
        .issue_imm(issue_imm), .issue_pc(issue_pc), .issue_dest(issue_dest),
        .alu_cdb_valid(alu_cdb_valid), .alu_cdb_tag(alu_cdb_tag), .alu_cdb_value(alu_cdb_value),
        .lsb_cdb_valid(lsb_cdb_valid), .lsb_cdb_tag(lsb_cdb_tag), .lsb_cdb_value(lsb_cdb_value),
        .rs_full(rs_full), .alu_valid(alu_valid), .alu_type(alu_type),
        .alu_a(alu_a), .alu_b(alu_b), .alu_imm(alu_imm), .alu_pc(alu_pc), .alu_dest(alu_dest)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_issue(input logic [5:0] t, input logic jb, input logic [3:0] qj,
                               input logic [31:0] vj, input logic kb, input logic [3:0] qk,
                               input logic [31:0] vk, input logic [31:0] imm,
                               input logic [31:0] pc, input logic [3:0] dest);
        issue_valid   = 1'b1;
        issue_is_calc = 1'b1;
        issue_type    = t;
        issue_qj_busy = jb;
        issue_qj      = qj;
        issue_vj      = vj;
        issue_qk_busy = kb;
        issue_qk      = qk;
        issue_vk      = vk;
        issue_imm     = imm;
        issue_pc      = pc;
        issue_dest    = dest;
    endtask

    initial begin
        rst = 1'b1; rdy = 1'b1; flush = 1'b0;
        issue_valid = 1'b0; issue_is_calc = 1'b0; issue_type = '0;
        issue_qj_busy = 1'b0; issue_qj = '0; issue_vj = '0;
        issue_qk_busy = 1'b0; issue_qk = '0; issue_vk = '0;
        issue_imm = '0; issue_pc = '0; issue_dest = '0;
        alu_cdb_valid = 1'b0; alu_cdb_tag = '0; alu_cdb_value = '0;
        lsb_cdb_valid = 1'b0; lsb_cdb_tag = '0; lsb_cdb_value = '0;
        tick();
        tick();
        chk("reset_valid", 32'(alu_valid), 32'd0);
        chk("reset_full", 32'(rs_full), 32'd0);
        chk("reset_dest", 32'(alu_dest), 32'd0);
        rst = 1'b0;

        // ADDI with ready operand: accept at N, dispatch at N+1
        drive_issue(T_ADDI, 1'b0, 4'd0, 32'd5, 1'b0, 4'd0, 32'd0, 32'd7, 32'h100, 4'd3);
        tick();
        issue_valid = 1'b0;
        chk("addi_no_early", 32'(alu_valid), 32'd0);
        tick();
        chk("addi_valid", 32'(alu_valid), 32'd1);
        chk("addi_a", alu_a, 32'd5);
        chk("addi_imm", alu_imm, 32'd7);
        chk("addi_dest", 32'(alu_dest), 32'd3);
        chk("addi_type", 32'(alu_type), 32'(T_ADDI));
        chk("addi_pc", alu_pc, 32'h100);
        tick();
        chk("addi_freed", 32'(alu_valid), 32'd0);
        chk("addi_hold_a", alu_a, 32'd5);

        // ADD waiting on tag 2, ALU CDB broadcasts two cycles later
        drive_issue(T_ADD, 1'b1, 4'd2, 32'd0, 1'b0, 4'd0, 32'd1, 32'd0, 32'h104, 4'd5);
        tick();
        issue_valid = 1'b0;
        tick();
        chk("add_wait", 32'(alu_valid), 32'd0);
        alu_cdb_valid = 1'b1; alu_cdb_tag = 4'd2; alu_cdb_value = 32'h10;
        tick();
        alu_cdb_valid = 1'b0;
        chk("add_capture_no_early", 32'(alu_valid), 32'd0);
        tick();
        chk("add_valid", 32'(alu_valid), 32'd1);
        chk("add_a", alu_a, 32'h10);
        chk("add_b", alu_b, 32'd1);
        chk("add_dest", 32'(alu_dest), 32'd5);

        // Issue-cycle capture from LSB CDB
        drive_issue(T_ADD, 1'b0, 4'd0, 32'd3, 1'b1, 4'd4, 32'd0, 32'd0, 32'h108, 4'd6);
        lsb_cdb_valid = 1'b1; lsb_cdb_tag = 4'd4; lsb_cdb_value = 32'd9;
        tick();
        issue_valid = 1'b0; lsb_cdb_valid = 1'b0;
        tick();
        chk("fwd_valid", 32'(alu_valid), 32'd1);
        chk("fwd_b", alu_b, 32'd9);
        chk("fwd_a", alu_a, 32'd3);
        chk("fwd_dest", 32'(alu_dest), 32'd6);

        // Fill all 8 entries waiting on tag 1
        for (int i = 0; i < 8; i++) begin
            drive_issue(T_ADD, 1'b1, 4'd1, 32'd0, 1'b0, 4'd0, 32'(i), 32'd0, 32'h200, 4'(i));
            tick();
            if (i == 6) chk("fill_not_full_7", 32'(rs_full), 32'd0);
        end
        chk("fill_full", 32'(rs_full), 32'd1);
        chk("fill_no_dispatch", 32'(alu_valid), 32'd0);
        drive_issue(T_ADD, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 32'd0, 32'h300, 4'd9);
        tick();
        issue_valid = 1'b0;
        chk("ninth_ignored_full", 32'(rs_full), 32'd1);
        chk("ninth_no_dispatch", 32'(alu_valid), 32'd0);
        alu_cdb_valid = 1'b1; alu_cdb_tag = 4'd1; alu_cdb_value = 32'h55;
        tick();
        alu_cdb_valid = 1'b0;
        chk("drain_full_before", 32'(rs_full), 32'd1);
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("drain_valid", 32'(alu_valid), 32'd1);
            chk("drain_dest", 32'(alu_dest), 32'(k));
            chk("drain_b", alu_b, 32'(k));
            if (k == 0) begin
                chk("drain_a", alu_a, 32'h55);
                chk("drain_full_drop", 32'(rs_full), 32'd0);
            end
        end
        tick();
        chk("drain_empty", 32'(alu_valid), 32'd0);

        // Flush with 3 busy entries, one ready
        drive_issue(T_ADD, 1'b1, 4'd6, 32'd0, 1'b0, 4'd0, 32'd0, 32'd0, 32'h400, 4'd10);
        tick();
        drive_issue(T_ADD, 1'b1, 4'd6, 32'd0, 1'b0, 4'd0, 32'd0, 32'd0, 32'h404, 4'd11);
        tick();
        drive_issue(T_ADDI, 1'b0, 4'd0, 32'd1, 1'b0, 4'd0, 32'd0, 32'd2, 32'h408, 4'd12);
        tick();
        issue_valid = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_valid", 32'(alu_valid), 32'd0);
        chk("flush_full", 32'(rs_full), 32'd0);
        drive_issue(T_ADDI, 1'b0, 4'd0, 32'd1, 1'b0, 4'd0, 32'd0, 32'd0, 32'h500, 4'd13);
        issue_is_calc = 1'b0;
        alu_cdb_valid = 1'b1; alu_cdb_tag = 4'd6; alu_cdb_value = 32'h66;
        tick();
        issue_valid = 1'b0; alu_cdb_valid = 1'b0;
        tick();
        chk("flush_gone", 32'(alu_valid), 32'd0);
        tick();
        chk("notcalc_ignored", 32'(alu_valid), 32'd0);

        // Asynchronous reset between edges while dispatching
        drive_issue(T_ADDI, 1'b0, 4'd0, 32'hAB, 1'b0, 4'd0, 32'd0, 32'd1, 32'h600, 4'd7);
        tick();
        issue_valid = 1'b0;
        tick();
        chk("pre_rst_valid", 32'(alu_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_valid", 32'(alu_valid), 32'd0);
        chk("rst_a", alu_a, 32'd0);
        chk("rst_dest", 32'(alu_dest), 32'd0);
        chk("rst_pc", alu_pc, 32'd0);
        #1;
        rst = 1'b0;

        // rdy=0 freezes outputs and blocks accept
        drive_issue(T_ADDI, 1'b0, 4'd0, 32'h11, 1'b0, 4'd0, 32'd0, 32'd0, 32'h700, 4'd1);
        tick();
        drive_issue(T_ADDI, 1'b0, 4'd0, 32'h22, 1'b0, 4'd0, 32'd0, 32'd0, 32'h704, 4'd2);
        tick();
        chk("rdy_first_valid", 32'(alu_valid), 32'd1);
        chk("rdy_first_dest", 32'(alu_dest), 32'd1);
        rdy = 1'b0;
        drive_issue(T_ADDI, 1'b0, 4'd0, 32'h33, 1'b0, 4'd0, 32'd0, 32'd0, 32'h708, 4'd3);
        tick();
        tick();
        chk("rdy_hold_valid", 32'(alu_valid), 32'd1);
        chk("rdy_hold_dest", 32'(alu_dest), 32'd1);
        chk("rdy_hold_a", alu_a, 32'h11);
        issue_valid = 1'b0;
        rdy = 1'b1;
        tick();
        chk("rdy_resume_dest", 32'(alu_dest), 32'd2);
        chk("rdy_resume_a", alu_a, 32'h22);
        tick();
        chk("rdy_no_accept", 32'(alu_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/calc_rs.md
Name: calc_rs

Overview:
- Reservation station for integer-calculate instructions (LUI/AUIPC, R-type ALU ops, I-type ALU ops) in the out-of-order core.
- Sits downstream of the decode/issue stage; accepts only instructions the calc classifier flags (is_calc=1).
- Buffers them until both operands are known, snooping the two common data buses (ALU CDB, LSB CDB).
- Dispatches one ready instruction per cycle to the ALU.

Parameters:
RS_SIZE, 8, number of entries (power of two, 2..16)
TYPE_W, 6, instruction-type code width (matches global INST_TYPE_WIDTH)
ROB_W, 4, ROB tag width
XLEN, 32, data width

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
rdy  in  1  global ready; 0 freezes all state and outputs
flush  in  1  mispredict flush, synchronous
issue_valid  in  1  issue stage presents an instruction
issue_is_calc  in  1  classifier result for issue_type
issue_type  in  TYPE_W  instruction type code
issue_qj_busy  in  1  operand j not yet available
issue_qj  in  ROB_W  producer tag for j
issue_vj  in  XLEN  value j (valid when qj_busy=0)
issue_qk_busy, issue_qk, issue_vk  in  1/ROB_W/XLEN  same for operand k
issue_imm  in  XLEN  immediate
issue_pc  in  XLEN  instruction PC
issue_dest  in  ROB_W  destination ROB tag
alu_cdb_valid, alu_cdb_tag, alu_cdb_value  in  1/ROB_W/XLEN  ALU broadcast
lsb_cdb_valid, lsb_cdb_tag, lsb_cdb_value  in  1/ROB_W/XLEN  LSB broadcast
rs_full  out  1  no free entry
alu_valid  out  1  dispatch strobe, one cycle
alu_type  out  TYPE_W
alu_a, alu_b, alu_imm, alu_pc  out  XLEN
alu_dest  out  ROB_W

Behaviour:
- Reset (async): all entries invalid; alu_valid=0; alu_type/alu_a/alu_b/alu_imm/alu_pc/alu_dest=0; rs_full=0.
- Entry fields: busy, type, qj_busy, qj, vj, qk_busy, qk, vk, imm, pc, dest.
- Accept condition: rdy & !flush & issue_valid & issue_is_calc & !rs_full.
  - Write into the lowest-index free entry at the clock edge.
  - is_calc=0 is silently ignored.
- Issue-cycle capture: if an incoming operand's busy bit is set and its tag matches a valid CDB in the same cycle, store the CDB value with busy cleared.
  - Both CDBs matching the same tag cannot occur; if it does, ALU CDB wins.
- CDB snoop: every cycle, each busy entry with qX_busy=1 and tag==cdb_tag (valid) captures the value and clears qX_busy. Both CDBs may update different operands of the same or different entries in one cycle.
- Ready: busy & !qj_busy & !qk_busy, evaluated on registered entry state (post-edge).
- Dispatch:
  - Each rdy cycle, select the lowest-index ready entry.
  - At the edge: register its fields onto the alu_* outputs, set alu_valid=1, free the entry.
  - If nothing is ready: alu_valid=0; other outputs hold.
- Latency: an instruction accepted with both operands ready at edge N dispatches at edge N+1 (alu_valid visible in cycle after N+1). An operand captured from a CDB at edge M allows dispatch at edge M+1.
- rs_full: combinational, 1 when all RS_SIZE entries are busy.
  - A same-cycle dispatch does not clear it; the freed slot is usable next cycle.
  - Accept and dispatch in one cycle use different entries.
- Flush: at the next edge, all entries invalid and alu_valid=0. Overrides accept, dispatch and snoop that cycle.
- rdy=0: no accept, no snoop, no dispatch; registers hold, including alu_valid. Upstream must not broadcast while rdy=0.
- Reset mid-operation: immediate clear regardless of clk.
- Operand mapping: rs_calc forwards vj/vk/imm/pc unchanged. The ALU selects imm vs vk and uses pc for AUIPC; for LUI and I-type, issue sets qk_busy=0.

Test Plan:
- ADDI, vj=5 ready, imm=7, dest=3 issued at edge 1 -> alu_valid=1 after edge 2 with alu_a=5, alu_imm=7, alu_dest=3; entry freed.
- ADD, qj_busy tag=2, vk=1; alu_cdb tag=2 value=0x10 two cycles later -> dispatch one edge after capture with alu_a=0x10, alu_b=1.
- Issue with qk tag=4 while lsb_cdb tag=4 value=9 in same cycle -> alu_b=9 at dispatch, no extra wait.
- Fill 8 entries all waiting on tag 1 -> rs_full=1; 9th issue ignored; alu_cdb tag=1 -> entries 0..7 dispatch in index order on 8 consecutive edges; rs_full drops after first dispatch.
- 3 entries busy with 1 ready; flush=1 -> next cycle all free, alu_valid=0, rs_full=0; is_calc=0 issue never occupies an entry.
- Assert rst between edges with alu_valid=1 -> alu_valid and all outputs 0 immediately; held rdy=0 -> outputs and entries unchanged.
